// File: rtl/mem_stage.sv
// ARM pipeline MEM stage: pass-through of EXE results plus a word-addressed data
// memory accessed through an IDLE/BUSY/DONE wait-state FSM. ready is held low while
// an access is in flight so the upstream pipeline freezes.
// Optional feature macro: MEM_STAGE_ERR_EN adds the registered memErr output that
// flags out-of-range or misaligned accesses during their DONE cycle.
module mem_stage #(
  parameter int unsigned DEPTH       = 64,   // data memory words, at least 2
  parameter int unsigned BASE_ADDR   = 1024, // byte address of word 0
  parameter int unsigned WAIT_CYCLES = 2     // BUSY cycles per access, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbEnIn,
  input  logic        memReadEnIn,
  input  logic        memWriteEnIn,
  input  logic [31:0] aluResultIn,
  input  logic [31:0] valRmIn,
  input  logic [3:0]  dstIn,
  output logic        wbEn,
  output logic        memReadEn,
  output logic [31:0] aluResult,
  output logic [3:0]  dst,
  output logic [31:0] memReadValue,
`ifdef MEM_STAGE_ERR_EN
  output logic        memErr,
`endif
  output logic        ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          launch;   // IDLE edge that captures a new request
  logic          finish;   // BUSY edge that performs the memory access

  logic          req;
  logic [31:0]   idx_full;
  logic          in_range;

  logic [AW-1:0] idx_q;
  logic [31:0]   data_q;
  logic          store_q;
  logic          in_range_q;
  logic [31:0]   rd_q;

  logic [31:0]   mem [DEPTH];

  // Pass-through outputs are purely combinational, so they follow inputs even in reset.
  assign wbEn      = wbEnIn;
  assign memReadEn = memReadEnIn;
  assign aluResult = aluResultIn;
  assign dst       = dstIn;

  assign req = memReadEnIn | memWriteEnIn;

  // Wrapping subtract: addresses below the base become huge indices and fall out of range.
  assign idx_full = (aluResultIn - 32'(BASE_ADDR)) >> 2;
  assign in_range = idx_full < 32'(DEPTH);

  // Next-state, wait counter and ready decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    launch  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = ~req;
        if (req) begin
          launch  = 1'b1;
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          finish  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request; upstream holds it anyway, but the access uses this snapshot.
  always_ff @(posedge clk) begin
    if (launch) begin
      idx_q      <= idx_full[AW-1:0];
      data_q     <= valRmIn;
      store_q    <= memWriteEnIn; // store wins when both enables are high
      in_range_q <= in_range;
    end
  end

  // Memory write; contents survive reset, but a reset edge cancels a pending store.
  always_ff @(posedge clk) begin
    if (!rst && finish && store_q && in_range_q) begin
      mem[idx_q] <= data_q;
    end
  end

  // Load data register; holds its value until the next load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 32'd0;
    end else if (finish && !store_q) begin
      rd_q <= in_range_q ? mem[idx_q] : 32'd0;
    end
  end

  assign memReadValue = rd_q;

`ifdef MEM_STAGE_ERR_EN
  logic fault_q;
  logic err_q;

  // Fault flag captured with the request: out of range or not word aligned.
  always_ff @(posedge clk) begin
    if (launch) begin
      fault_q <= ~in_range | (|aluResultIn[1:0]);
    end
  end

  // Set on the access edge, so it is high for exactly the following DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= finish & fault_q;
    end
  end

  assign memErr = err_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (WAIT_CYCLES=2, DEPTH=64, BASE_ADDR=1024).
// The driver pushes an expected record per instruction; the monitor pops one each
// time the stage advances (ready high) and checks outputs and cycle count.
module tb_mem_stage;

  localparam int MemLat = 4; // WAIT_CYCLES + 2
  localparam int AluLat = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en_in = 1'b0, rd_en_in = 1'b0, wr_en_in = 1'b0;
  logic [31:0] alu_in = 32'd0, val_in = 32'd0;
  logic [3:0]  dst_in = 4'd0;
  logic        wb_en, rd_en, ready;
  logic [31:0] alu_out, rd_val;
  logic [3:0]  dst_out;
`ifdef MEM_STAGE_ERR_EN
  logic        mem_err;
`endif

  typedef struct {
    logic [31:0] alu;
    logic [3:0]  dst;
    logic        wb;
    logic        rd;
    logic [31:0] rv;
    int          lat;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic active = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wbEnIn       (wb_en_in),
    .memReadEnIn  (rd_en_in),
    .memWriteEnIn (wr_en_in),
    .aluResultIn  (alu_in),
    .valRmIn      (val_in),
    .dstIn        (dst_in),
    .wbEn         (wb_en),
    .memReadEn    (rd_en),
    .aluResult    (alu_out),
    .dst          (dst_out),
    .memReadValue (rd_val),
`ifdef MEM_STAGE_ERR_EN
    .memErr       (mem_err),
`endif
    .ready        (ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction, record its expected response, hold until it advances.
  task automatic issue(input logic wb, input logic rdn, input logic wr,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] d,
                       input logic [31:0] exp_rv, input int lat, input logic err);
    exp_t e;
    bit   seen;
    wb_en_in = wb; rd_en_in = rdn; wr_en_in = wr;
    alu_in = alu; val_in = val; dst_in = d;
    e.alu = alu; e.dst = d; e.wb = wb; e.rd = rdn; e.rv = exp_rv; e.lat = lat; e.err = err;
    q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready never rose for addr %h", alu);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: each advance pops one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (active && !rst) begin
      cyc = cyc + 1;
      if (ready === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_advance: got advance at alu %h expected none", alu_out);
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc), 32'(e.lat));
          chk("memReadValue", rd_val, e.rv);
          chk("aluResult", alu_out, e.alu);
          chk("dst", 32'(dst_out), 32'(e.dst));
          chk("wbEn", 32'(wb_en), 32'(e.wb));
          chk("memReadEn", 32'(rd_en), 32'(e.rd));
`ifdef MEM_STAGE_ERR_EN
          chk("memErr", 32'(mem_err), 32'(e.err));
`endif
        end
        cyc = 0;
      end
    end else begin
      cyc = 0;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    active = 1'b1;

    // Non-memory instructions: zero stall, pass-through, memReadValue still reset value.
    //    wb    rd    wr    alu           val           dst    rv            lat     err
    issue(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,        4'd5,  32'h0,        AluLat, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        4'd15, 32'h0,        AluLat, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h5,        4'd0,  32'h0,        AluLat, 1'b0);
    // Store then load mem[2].
    issue(1'b0, 1'b0, 1'b1, 32'h0000_0408, 32'hDEADBEEF, 4'd1,  32'h0,        MemLat, 1'b0);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0408, 32'h0,        4'd3,  32'hDEADBEEF, MemLat, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0007, 32'h0,        4'd2,  32'hDEADBEEF, AluLat, 1'b0);
    // Word 0 seeded to detect an out-of-range store wrapping onto it.
    issue(1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000A0A0, 4'd0,  32'hDEADBEEF, MemLat, 1'b0);
    // Out of range load (idx 64) and misaligned load of word 2.
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0,        4'd4,  32'h0,        MemLat, 1'b1);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0409, 32'h0,        4'd4,  32'hDEADBEEF, MemLat, 1'b1);
    // Last word (idx 63).
    issue(1'b0, 1'b0, 1'b1, 32'h0000_04FC, 32'h00000077, 4'd6,  32'hDEADBEEF, MemLat, 1'b0);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_04FC, 32'h0,        4'd6,  32'h00000077, MemLat, 1'b0);
    // Below base: wraps to a huge index.
    issue(1'b1, 1'b1, 1'b0, 32'h0000_03FC, 32'h0,        4'd7,  32'h0,        MemLat, 1'b1);
    // Dropped out-of-range store must not touch word 0.
    issue(1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h00000099, 4'd7,  32'h0,        MemLat, 1'b1);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0,        4'd8,  32'h0000A0A0, MemLat, 1'b0);
    // Seed mem[3], then load word 2 so memReadValue is non-zero before the abort.
    issue(1'b0, 1'b0, 1'b1, 32'h0000_040C, 32'hCAFE0003, 4'd9,  32'h0000A0A0, MemLat, 1'b0);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0408, 32'h0,        4'd9,  32'hDEADBEEF, MemLat, 1'b0);

    // Store 0x11 to mem[3], aborted by reset in its first BUSY cycle.
    wb_en_in = 1'b0; rd_en_in = 1'b0; wr_en_in = 1'b1;
    alu_in = 32'h0000_040C; val_in = 32'h0000_0011; dst_in = 4'd10;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_passthrough_alu", alu_out, 32'h0000_040C);
    chk("reset_passthrough_dst", 32'(dst_out), 32'd10);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_memReadValue", rd_val, 32'h0);

    issue(1'b1, 1'b1, 1'b0, 32'h0000_040C, 32'h0,        4'd10, 32'hCAFE0003, MemLat, 1'b0);
    // Both enables: store wins, memReadValue holds.
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0410, 32'h00000055, 4'd11, 32'hCAFE0003, MemLat, 1'b0);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0410, 32'h0,        4'd11, 32'h00000055, MemLat, 1'b0);

    wb_en_in = 1'b0; rd_en_in = 1'b0; wr_en_in = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    active = 1'b0;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
